// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_pkg
// Purpose : Shared types and constants for the execute-stage mul/div unit.
//           muldiv_op_t    - operation encoding carried on the op field
//           muldiv_state_t - sequencer states
//           MULDIV_WIDTH   - default operand / hi / lo width
// Ports   : none (package)
// Config  : MULDIV_SIGNED_EN (consumed by execute_muldiv_unit)
// Revision: 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 16;

  typedef enum logic [1:0] {
    MULU = 2'b00,
    MUL  = 2'b01,
    DIVU = 2'b10,
    DIV  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : execute_muldiv_unit_if
// Purpose : Request / result bundle between the decode/execute pipeline and
//           the mul/div unit.
// Ports   : master - pipeline side: drives start, op, opa, opb, mthi, mtlo,
//                    wdata; observes hi, lo, busy, stall, done, div0
//           slave  - mul/div unit side (mirror of master)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
interface execute_muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div0;

  modport master (
    output start, op, opa, opb, mthi, mtlo, wdata,
    input  hi, lo, busy, stall, done, div0
  );

  modport slave (
    input  start, op, opa, opb, mthi, mtlo, wdata,
    output hi, lo, busy, stall, done, div0
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_iter_step.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_iter_step
// Purpose : One combinational iteration of the mul/div datapath.
//           Multiply: {acc, mq} holds partial product / remaining multiplier;
//             add operand when mq[0] is set, then shift the pair right.
//           Divide: acc is the partial remainder, mq shifts the dividend out
//             at the top and collects quotient bits at the bottom (restoring).
// Ports   : div_mode      in  select divide (1) or multiply (0) step
//           acc, mq       in  current accumulator / shift register
//           operand       in  multiplicand or divisor magnitude
//           acc_next, mq_next out  state after this iteration
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] trial;

  always_comb begin
    // Extra top bit on sum keeps the carry that shifts back into acc.
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
    shifted = {acc, mq[WIDTH-1]};
    fits    = (shifted >= {1'b0, operand});
    // Only used when fits: the difference is then below operand, so the
    // modular low-half subtraction is exact.
    trial   = shifted[WIDTH-1:0] - operand;

    if (div_mode) begin
      acc_next = fits ? trial : shifted[WIDTH-1:0];
      mq_next  = {mq[WIDTH-2:0], fits};
    end else begin
      acc_next = sum[WIDTH:1];
      mq_next  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : execute_muldiv_unit
// Purpose : Iterative multiply / divide responder with architectural hi/lo.
//           IDLE -> CALC (WIDTH iterations) -> FINISH (sign fix, write hi/lo,
//           pulse done). busy/stall cover WIDTH+1 cycles after start.
// Ports   : clk    in   clock
//           reset  in   synchronous active-high reset
//           bus    slave execute_muldiv_unit_if (start/op/opa/opb/mthi/mtlo/
//                  wdata in; hi/lo/busy/stall/done/div0 out)
// Config  : MULDIV_SIGNED_EN - when defined, ops MUL and DIV are signed;
//           otherwise op[0] is ignored and everything is unsigned.
// Revision: 1.0 - initial release
// ============================================================================
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  execute_muldiv_unit_if.slave  bus
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

  muldiv_state_t    state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, mq, operand, dividend_raw;
  logic             is_div, div_zero;
  logic [WIDTH-1:0] acc_step, mq_step;
  logic [WIDTH-1:0] hi, lo;
  logic             done, div0;

  muldiv_op_t       op_in;
  logic             start_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_in     = muldiv_op_t'(bus.op);
  assign start_div = (op_in == DIVU) || (op_in == DIV);

`ifdef MULDIV_SIGNED_EN
  logic start_signed, a_neg, b_neg;
  logic neg_res, neg_rem;   // latched at start: result / remainder negation
  logic [2*WIDTH-1:0] product_neg;

  always_comb begin
    start_signed = (op_in == MUL) || (op_in == DIV);
    a_neg        = start_signed & bus.opa[WIDTH-1];
    b_neg        = start_signed & bus.opb[WIDTH-1];
    a_mag        = a_neg ? -bus.opa : bus.opa;
    b_mag        = b_neg ? -bus.opb : bus.opb;
  end

  assign product_neg = -{acc, mq};

  always_comb begin
    res_hi = acc;
    res_lo = mq;
    if (is_div) begin
      if (div_zero) begin
        res_hi = dividend_raw;
        res_lo = '1;
      end else begin
        if (neg_res) res_lo = -mq;
        if (neg_rem) res_hi = -acc;
      end
    end else if (neg_res) begin
      res_hi = product_neg[2*WIDTH-1:WIDTH];
      res_lo = product_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
    end
  end
`else
  assign a_mag = bus.opa;
  assign b_mag = bus.opb;

  always_comb begin
    res_hi = acc;
    res_lo = mq;
    if (is_div && div_zero) begin
      res_hi = dividend_raw;
      res_lo = '1;
    end
  end
`endif

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc      (acc),
    .mq       (mq),
    .operand  (operand),
    .acc_next (acc_step),
    .mq_next  (mq_step)
  );

  // Sequencer: state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Sequencer: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (count == LAST_ITER) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, hi/lo and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      acc          <= '0;
      mq           <= '0;
      operand      <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      div_zero     <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
      div0         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // start takes priority; a simultaneous direct write is dropped
            count        <= '0;
            acc          <= '0;
            mq           <= a_mag;
            operand      <= b_mag;
            dividend_raw <= bus.opa;
            is_div       <= start_div;
            div_zero     <= start_div && (bus.opb == '0);
          end else begin
            if (bus.mthi) hi <= bus.wdata;
            if (bus.mtlo) lo <= bus.wdata;
          end
        end
        CALC: begin
          acc   <= acc_step;
          mq    <= mq_step;
          count <= (count == LAST_ITER) ? '0 : count + 1'b1;
        end
        FINISH: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
          div0 <= div_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.busy  = (state != IDLE);
  assign bus.stall = (state != IDLE);
  assign bus.done  = done;
  assign bus.div0  = div0;

endmodule
`default_nettype wire

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Execute-stage responder for the multiply/divide and hi/lo fields issued through the decode/execute pipeline register. It accepts a start request with two operands, runs an iterative 16-step shift-add multiply or restoring divide, and writes the results into the architectural hi/lo registers. It asserts `stall` back to the fetch/decode/execute registers while busy, and also serves direct hi/lo moves.

## Interface
Parameters:
- `WIDTH`, 16, operand and hi/lo width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request a mul/div; sampled only in IDLE
- `op`  in  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
- `opa`  in  WIDTH  multiplicand / dividend
- `opb`  in  WIDTH  multiplier / divisor
- `mthi`  in  1  direct write of `wdata` to hi
- `mtlo`  in  1  direct write of `wdata` to lo
- `wdata`  in  WIDTH  direct-write data
- `hi`  out  WIDTH  hi register
- `lo`  out  WIDTH  lo register
- `busy`  out  1  operation in progress
- `stall`  out  1  hold upstream pipeline registers; equals `busy`
- `done`  out  1  one-cycle pulse when hi/lo are updated by an operation
- `div0`  out  1  sticky flag: last completed operation was a divide by zero

## Operation
- States:
  - IDLE: on `start`, latch `op`, `opa` and `opb`, and go to CALC.
  - CALC: counter runs 0..WIDTH-1, with one iteration per cycle. After iteration WIDTH-1, go to FINISH.
  - FINISH: apply sign correction, write hi/lo, pulse `done`, return to IDLE.
- Signed ops: take absolute values at start, run the unsigned algorithm, then fix signs in FINISH.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Multiply: 2·WIDTH-bit product, with hi = upper half and lo = lower half.
- Divide: lo = quotient, hi = remainder.
- Divide by zero: flagged at start and latency is unchanged. Result is lo = all ones, hi = `opa`, and `div0` is set at FINISH.
- Non-zero-divisor completions clear `div0`; multiply completions also clear it.
- Signed overflow (−32768 / −1): lo = 0x8000, hi = 0x0000 (natural wrap). No flag.
- Direct writes (`mthi`/`mtlo`) are honoured only in IDLE. Both may be asserted in the same cycle, in which case both registers take `wdata`.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the direct write is dropped.
- `start`, `mthi` and `mtlo` while busy: ignored. Upstream must hold the instruction under `stall`.
- `op`, `opa` and `opb` are don't-care except in the cycle `start` is sampled.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `stall` = 0, `done` = 0, `div0` = 0, state IDLE, counter 0.
- `start` is sampled at edge E0.
- `busy`/`stall` are high from E0 through E(WIDTH+1), i.e. WIDTH+1 = 17 cycles.
- At E(WIDTH+1) = E17, hi/lo are written and `done` is high for the following cycle.
- `busy` is low in that same cycle, so a back-to-back `start` may be sampled at E18.
- `busy` and `stall` are registered state decodes, with no combinational path from `start`.
- Reset during CALC or FINISH forces IDLE at the next edge. Hi/lo are zeroed, no `done` is issued, and the partial result is discarded.
- Direct writes take effect at the sampling edge and are visible next cycle.

## Configuration
- `MULDIV_SIGNED_EN` defined: ops 01 and 11 are signed as described above.
- Not defined:
  - `op[0]` is ignored and all ops are unsigned.
  - Sign/abs logic is removed.
  - FINISH still occupies one cycle, so latency is identical.

## Structure
- Package `muldiv_pkg` holds:
  - the `muldiv_op_t` enum (MULU, MUL, DIVU, DIV);
  - the `muldiv_state_t` enum (IDLE, CALC, FINISH);
  - the constant `MULDIV_WIDTH` = 16.
- One sub-module, `muldiv_iter_step`, is combinational and implements a single iteration.
  - Multiply mode: conditional add plus right shift of the {acc, multiplier} pair.
  - Divide mode: left shift plus trial subtract with quotient-bit insert.
- The top level holds the FSM, counter, operand latches, sign fix-up and hi/lo registers.

## Test plan
- MULU 0xFFFF × 0xFFFF → hi = 0xFFFE, lo = 0x0001, `done` in the cycle after E17, `busy` high for exactly 17 cycles.
- MUL signed 0xFFFD (−3) × 0x0005 → hi = 0xFFFF, lo = 0xFFF1. With `MULDIV_SIGNED_EN` undefined → hi = 0x0004, lo = 0xFFF1.
- DIVU 100 / 7 → lo = 0x000E, hi = 0x0002, `div0` = 0. Then DIV signed 0xFFF9 (−7) / 2 → lo = 0xFFFD, hi = 0xFFFF.
- DIVU 0x0005 / 0 → lo = 0xFFFF, hi = 0x0005, `div0` = 1. A following MULU 2 × 3 clears `div0` and gives lo = 6.
- `mthi` 0x1234 in IDLE → hi = 0x1234 next cycle. `mtlo` while busy → lo unchanged. `start` with `mtlo` in IDLE → only the operation executes.
- Reset asserted 8 cycles into CALC → next cycle `busy` = 0, hi = lo = 0, no `done` pulse. A second `start` while busy → ignored, and the original result is still produced.
